// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the keypad entry / display block.
//   KEY_BKSP, KEY_CLR, KEY_ENT : key codes with a command meaning
//   key_class_e                : classification of a decoded key code
//   classify_key()             : maps a 4-bit key code onto its class
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_DIGIT,
    KC_BKSP,
    KC_CLR,
    KC_ENT
  } key_class_e;

  // Codes 0xB, 0xD and 0xF have no function and fall into KC_NONE.
  function automatic key_class_e classify_key(input logic [3:0] code);
    key_class_e kc;
    if (code <= 4'h9)          kc = KC_DIGIT;
    else if (code == KEY_BKSP) kc = KC_BKSP;
    else if (code == KEY_CLR)  kc = KC_CLR;
    else if (code == KEY_ENT)  kc = KC_ENT;
    else                       kc = KC_NONE;
    return kc;
  endfunction

endpackage

// File: rtl/disp_ctrl.sv
// disp_ctrl -- combinational hex-to-seven-segment decoder.
//   hex   : 4-bit value 0x0..0xF to show
//   blank : forces all segments off
//   seg   : active-high segments, seg[0]=a .. seg[6]=g
module disp_ctrl (
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    if (!blank) begin
      case (hex)
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        default: seg = 7'h71;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_disp.sv
// keypad_entry_disp -- keypad digit entry buffer with a multiplexed
// seven-segment display of the buffer.
//   pulse_50Mhz : system clock
//   rst_n       : asynchronous active-low reset
//   key_valid   : single-cycle strobe qualifying key_code
//   key_code    : decoded key (0-9 digit, A backspace, C clear, E enter)
//   clear       : level clear of the entry buffer, wins over key_valid
//   digits      : entry buffer, newest digit in [3:0]
//   count       : number of digits currently entered
//   value       : buffer contents captured by the last accepted ENTER
//   value_valid : one-cycle strobe when value is updated
//   seg         : active-high segments a..g of the selected digit
//   dig_sel     : one-hot digit enable
module keypad_entry_disp
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int REFRESH_HZ    = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                            pulse_50Mhz,
  input  logic                            rst_n,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  input  logic                            clear,
  output logic [4*NUM_DIGITS-1:0]         digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic [4*NUM_DIGITS-1:0]         value,
  output logic                            value_valid,
  output logic [6:0]                      seg,
  output logic [NUM_DIGITS-1:0]           dig_sel
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CW      = $clog2(NUM_DIGITS + 1);
  localparam int SW      = $clog2(NUM_DIGITS);
  localparam int DIV_RAW = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int RW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]         digits_q, digits_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DW-1:0]         value_q, value_d;
  logic                  value_valid_q, value_valid_d;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [6:0]            seg_q, seg_d;

  key_class_e key_class;
  logic       tick;
  logic [3:0] sel_nib;
  logic       sel_blank;

  assign key_class = classify_key(key_code);

  // Entry buffer: clear input first, then the key command.
  always_comb begin
    digits_d      = digits_q;
    count_d       = count_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (key_valid) begin
      case (key_class)
        KC_DIGIT: begin
          if (count_q < CW'(NUM_DIGITS)) begin
            digits_d = {digits_q[DW-5:0], key_code};
            count_d  = count_q + 1'b1;
          end
        end
        KC_BKSP: begin
          if (count_q != '0) begin
            digits_d = {4'h0, digits_q[DW-1:4]};
            count_d  = count_q - 1'b1;
          end
        end
        KC_CLR: begin
          digits_d = '0;
          count_d  = '0;
        end
        KC_ENT: begin
          // The commit and the buffer clear land on the same edge.
          if (count_q != '0) begin
            value_d       = digits_q;
            value_valid_d = 1'b1;
            digits_d      = '0;
            count_d       = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Refresh divider and scan position.
  assign tick = (ref_cnt_q == RW'(DIV - 1));

  always_comb begin
    ref_cnt_d = tick ? '0 : ref_cnt_q + 1'b1;
    scan_d    = scan_q;
    if (tick) begin
      scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

  // Decode from next-state values so the registered seg/dig_sel pair
  // reflects the buffer on the very edge a key lands, with no extra lag.
  always_comb begin
    dig_sel_d = NUM_DIGITS'(1) << scan_d;
    sel_nib   = digits_d[{scan_d, 2'b00} +: 4];
    sel_blank = (BLANK_LEADING != 0) && (CW'(scan_d) >= count_d) &&
                !((scan_d == '0) && (count_d == '0));
  end

  disp_ctrl u_disp_ctrl (
    .hex   (sel_nib),
    .blank (sel_blank),
    .seg   (seg_d)
  );

  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      digits_q      <= '0;
      count_q       <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      ref_cnt_q     <= '0;
      scan_q        <= '0;
      dig_sel_q     <= NUM_DIGITS'(1);
      seg_q         <= 7'h00;
    end else begin
      digits_q      <= digits_d;
      count_q       <= count_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      ref_cnt_q     <= ref_cnt_d;
      scan_q        <= scan_d;
      dig_sel_q     <= dig_sel_d;
      seg_q         <= seg_d;
    end
  end

  assign digits      = digits_q;
  assign count       = count_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;

endmodule

// File: tb/tb_keypad_entry_disp.sv
module tb_keypad_entry_disp;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        clear;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] value;
  logic        value_valid;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int checks = 0;
  int errors = 0;

  keypad_entry_disp #(
    .NUM_DIGITS    (4),
    .CLK_FREQ      (400),
    .REFRESH_HZ    (25),
    .BLANK_LEADING (1)
  ) dut (
    .pulse_50Mhz (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .clear       (clear),
    .digits      (digits),
    .count       (count),
    .value       (value),
    .value_valid (value_valid),
    .seg         (seg),
    .dig_sel     (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key is presented for one cycle; returns 1 time unit after the capturing edge.
  task automatic press(input logic [3:0] code);
    @(posedge clk);
    #1 key_valid = 1'b1;
    key_code = code;
    @(posedge clk);
    #1 key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    clear     = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_vv", 32'(value_valid), 32'h0);
    check("rst_dig_sel", 32'(dig_sel), 32'h1);
    check("rst_seg", 32'(seg), 32'h0);
    rst_n = 1'b1;

    // Scan: divider 400/(25*4)=4. Release before edge E1, so ticks at E4, E8, ...
    // Key 5 is captured at E2.
    press(4'h5);
    check("scan_count1", 32'(count), 32'h1);
    for (int n = 2; n < 18; n++) begin
      if (n > 2) begin
        @(posedge clk);
        #1;
      end
      exp_sel = 4'b0001 << ((n / 4) % 4);
      exp_seg = (((n / 4) % 4) == 0) ? 7'h6D : 7'h00;
      check($sformatf("scan_sel_e%0d", n), 32'(dig_sel), 32'(exp_sel));
      check($sformatf("scan_seg_e%0d", n), 32'(seg), 32'(exp_seg));
    end

    pulse_clear();
    check("clr_in_count", 32'(count), 32'h0);
    check("clr_in_digits", 32'(digits), 32'h0);

    // Fill and overflow
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    check("fill_digits", 32'(digits), 32'h1234);
    check("fill_count", 32'(count), 32'h4);
    press(4'h5);
    check("ovf_digits", 32'(digits), 32'h1234);
    check("ovf_count", 32'(count), 32'h4);

    // Backspace and underflow
    press(4'hA);
    press(4'hA);
    check("bksp2_digits", 32'(digits), 32'h0012);
    check("bksp2_count", 32'(count), 32'h2);
    press(4'hA);
    press(4'hA);
    check("bksp4_digits", 32'(digits), 32'h0000);
    check("bksp4_count", 32'(count), 32'h0);
    press(4'hA);
    check("bksp5_count", 32'(count), 32'h0);

    // Enter
    press(4'h7);
    press(4'h8);
    press(4'hE);
    check("ent_value", 32'(value), 32'h0078);
    check("ent_vv", 32'(value_valid), 32'h1);
    check("ent_count", 32'(count), 32'h0);
    check("ent_digits", 32'(digits), 32'h0);
    @(posedge clk);
    #1;
    check("ent_vv_drop", 32'(value_valid), 32'h0);
    press(4'hE);
    check("ent0_vv", 32'(value_valid), 32'h0);
    check("ent0_value", 32'(value), 32'h0078);

    // CLEAR key and backspace keep value; ignored codes
    press(4'h3);
    press(4'hC);
    check("clrkey_count", 32'(count), 32'h0);
    check("clrkey_value", 32'(value), 32'h0078);
    press(4'h6);
    press(4'hB);
    press(4'hD);
    press(4'hF);
    check("ign_digits", 32'(digits), 32'h0006);
    check("ign_count", 32'(count), 32'h1);
    press(4'hA);
    check("bksp_value", 32'(value), 32'h0078);

    // clear input wins over a simultaneous key
    press(4'h6);
    @(posedge clk);
    #1 clear = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h9;
    @(posedge clk);
    #1 clear = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    check("clrpri_count", 32'(count), 32'h0);
    check("clrpri_digits", 32'(digits), 32'h0);

    // Asynchronous reset mid-entry
    press(4'h1);
    press(4'h2);
    check("pre_rst_count", 32'(count), 32'h2);
    rst_n = 1'b0;
    #1;
    check("arst_digits", 32'(digits), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_value", 32'(value), 32'h0);
    check("arst_vv", 32'(value_valid), 32'h0);
    check("arst_dig_sel", 32'(dig_sel), 32'h1);
    check("arst_seg", 32'(seg), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
